// File: rtl/dvs_ravens_pkg.sv
// dvs_ravens_pkg
// Shared definitions for the DVS-to-RAVENS event path.
//   EVENT_BITS             width of one decoded DVS event word
//   TIMESTAMP_US_BITS      microsecond timestamp field, event[TIMESTAMP_US_BITS-1:0]
//   DVS_FIFO_DEPTH_DEFAULT default number of entries in dvs_event_fifo
//   fifo_grant_state_t     states of the FIFO bus grant FSM
package dvs_ravens_pkg;

    localparam int TIMESTAMP_US_BITS      = 16;
    localparam int EVENT_BITS             = 32;
    localparam int DVS_FIFO_DEPTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        GRANT_WAIT = 2'd1,
        GAP        = 2'd2
    } fifo_grant_state_t;

endpackage

// File: rtl/dvs_fifo_bus_arbiter.sv
// dvs_fifo_bus_arbiter
// Grant FSM for the FIFO bus. Issues a single one-cycle grant per read so
// that one consumer request pops exactly one event, then holds off for a
// short gap so the consumer can drop fifo_req before it could be granted again.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   fifo_req     consumer ready for the next event
//   fifo_rd_en   consumer pop strobe
//   empty        FIFO holds no events
//   fifo_grant   one-cycle grant pulse (combinational from IDLE state)
//   pop          FIFO should pop its head entry on this edge
module dvs_fifo_bus_arbiter
    import dvs_ravens_pkg::*;
#(
    parameter int REGRANT_GAP = 2,
    parameter int RD_TIMEOUT  = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic fifo_req,
    input  logic fifo_rd_en,
    input  logic empty,
    output logic fifo_grant,
    output logic pop
);

    localparam int TO_W  = $clog2(RD_TIMEOUT);
    localparam int GAP_W = $clog2(REGRANT_GAP) + 1;

    fifo_grant_state_t state_q, state_d;
    logic [TO_W-1:0]   toCnt_q, toCnt_d;
    logic [GAP_W-1:0]  gapCnt_q, gapCnt_d;

    // The grant leaves IDLE in the same cycle it is raised, which is what
    // keeps it from ever asserting in two consecutive cycles. The timeout
    // counter restarts on every grant, the gap counter on every pop.
    always_comb begin
        state_d    = state_q;
        toCnt_d    = toCnt_q;
        gapCnt_d   = gapCnt_q;
        fifo_grant = 1'b0;
        pop        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fifo_req && !empty) begin
                    fifo_grant = 1'b1;
                    toCnt_d    = '0;
                    state_d    = GRANT_WAIT;
                end
            end
            GRANT_WAIT: begin
                if (fifo_rd_en && !empty) begin
                    pop      = 1'b1;
                    gapCnt_d = GAP_W'(REGRANT_GAP - 1);
                    state_d  = GAP;
                end else if (toCnt_q == TO_W'(RD_TIMEOUT - 1)) begin
                    state_d = IDLE;
                end else begin
                    toCnt_d = toCnt_q + TO_W'(1);
                end
            end
            GAP: begin
                if (gapCnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gapCnt_d = gapCnt_q - GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            toCnt_q  <= '0;
            gapCnt_q <= '0;
        end else begin
            state_q  <= state_d;
            toCnt_q  <= toCnt_d;
            gapCnt_q <= gapCnt_d;
        end
    end

endmodule

// File: rtl/dvs_event_fifo.sv
// dvs_event_fifo
// Circular FIFO buffering decoded DVS events from the camera front end and
// serving them over the req/grant/rd_en FIFO bus to the event-to-RAVENS stage.
// Writes arriving while full (with no same-cycle pop) are dropped and flagged
// by the sticky overflow output.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   wr_en        front end presents an event this cycle
//   wr_event     event to store
//   fifo_req     consumer ready for next event
//   fifo_rd_en   consumer pop strobe
//   fifo_grant   one-cycle grant pulse
//   fifo_event   registered head event, valid the cycle after the pop
//   full, empty  occupancy flags
//   count        occupancy
//   overflow     sticky drop flag
//   drop_cnt     saturating dropped-write count (only with DVS_FIFO_DROP_CNT_EN)
// Optional feature macro: DVS_FIFO_DROP_CNT_EN adds the drop_cnt output.
module dvs_event_fifo
    import dvs_ravens_pkg::*;
#(
    parameter int DEPTH       = DVS_FIFO_DEPTH_DEFAULT,
    parameter int REGRANT_GAP = 2,
    parameter int RD_TIMEOUT  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [EVENT_BITS-1:0]      wr_event,
    input  logic                       fifo_req,
    input  logic                       fifo_rd_en,
    output logic                       fifo_grant,
    output logic [EVENT_BITS-1:0]      fifo_event,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
`ifdef DVS_FIFO_DROP_CNT_EN
    ,
    output logic [15:0]                drop_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [EVENT_BITS-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wrPtr_q, rdPtr_q;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [EVENT_BITS-1:0] fifoEvent_q;
    logic                  overflow_q;
    logic                  pop;
    logic                  wrAccept;
    logic                  wrDrop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign fifo_event = fifoEvent_q;
    assign overflow   = overflow_q;

    // A full FIFO still accepts a write when the head leaves on the same
    // edge; the pop reads the old head before the slot is overwritten.
    assign wrAccept = wr_en && (!full || pop);
    assign wrDrop   = wr_en && full && !pop;

    dvs_fifo_bus_arbiter #(
        .REGRANT_GAP (REGRANT_GAP),
        .RD_TIMEOUT  (RD_TIMEOUT)
    ) u_arbiter (
        .clk        (clk),
        .rst        (rst),
        .fifo_req   (fifo_req),
        .fifo_rd_en (fifo_rd_en),
        .empty      (empty),
        .fifo_grant (fifo_grant),
        .pop        (pop)
    );

    always_comb begin
        count_d = count_q;
        if (wrAccept && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!wrAccept && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Storage array is not reset; stale entries are never visible because
    // count and the pointers are.
    always_ff @(posedge clk) begin
        if (wrAccept) begin
            mem_q[wrPtr_q] <= wr_event;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            fifoEvent_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            if (wrAccept) begin
                wrPtr_q <= wrPtr_q + PTR_W'(1);
            end
            if (pop) begin
                fifoEvent_q <= mem_q[rdPtr_q];
                rdPtr_q     <= rdPtr_q + PTR_W'(1);
            end
            if (wrDrop) begin
                overflow_q <= 1'b1;
            end
        end
    end

`ifdef DVS_FIFO_DROP_CNT_EN
    logic [15:0] dropCnt_q;

    assign drop_cnt = dropCnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dropCnt_q <= '0;
        end else if (wrDrop && (dropCnt_q != 16'hFFFF)) begin
            dropCnt_q <= dropCnt_q + 16'd1;
        end
    end
`endif

endmodule
